// File: rtl/cpu_bus_byte_responder_if.sv
// CPU request/ready bus carrying one 32-bit word transaction at a time.
interface cpu_bus_byte_responder_if;
  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (
    output i_request, i_rw, i_address, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata,
    output o_rdata, o_ready
  );
endinterface

// File: rtl/cpu_bus_byte_responder.sv
// Serves 32-bit CPU bus reads/writes as four little-endian byte accesses
// on an 8-bit synchronous memory port with a fixed read latency.
module cpu_bus_byte_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  cpu_bus_byte_responder_if.slave bus,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_re,
  output logic                  o_mem_we,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic                  rw_q;
  logic [31:0]           wdata_q;
  logic [1:0]            k_q;
  logic [3:0]            cnt_q;
  logic [23:0]           rbuf_q;
  logic [31:0]           rdata_q;

  assign o_mem_address = {addr_q, k_q};
  assign o_mem_wdata   = wdata_q[{k_q, 3'b000} +: 8];
  assign bus.o_rdata   = rdata_q;
  assign bus.o_ready   = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    o_mem_re = 1'b0;
    o_mem_we = 1'b0;
    case (state_q)
      IDLE: if (bus.i_request) state_d = ISSUE;
      ISSUE: begin
        if (rw_q) begin
          o_mem_we = 1'b1;
          if (k_q == 2'd3) state_d = DONE;
        end else begin
          o_mem_re = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: if (cnt_q <= 4'd1) state_d = (k_q == 2'd3) ? DONE : ISSUE;
      DONE: state_d = HOLD;
      HOLD: if (!bus.i_request) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.i_request) begin
            addr_q  <= bus.i_address[ADDR_WIDTH-1:2];
            rw_q    <= bus.i_rw;
            wdata_q <= bus.i_wdata;
            k_q     <= '0;
          end
        end
        ISSUE: begin
          if (rw_q) begin
            if (k_q != 2'd3) k_q <= k_q + 2'd1;
          end else begin
            cnt_q <= 4'(LATENCY);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            // Bytes 0..2 collect in a shadow so o_rdata only changes when a read completes.
            if (k_q == 2'd3) begin
              rdata_q <= {i_mem_rdata, rbuf_q};
            end else begin
              rbuf_q[{k_q, 3'b000} +: 8] <= i_mem_rdata;
              k_q                        <= k_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_byte_responder.sv
// Randomized scoreboard bench: driver queues expected strobes/responses, a
// negedge monitor pops and compares whatever the DUT presents.
module tb_cpu_bus_byte_responder;
  localparam int unsigned AW  = 16;
  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } strobe_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = '0;
  logic [AW-1:0] mem_address;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  cpu_bus_byte_responder_if bus ();

  cpu_bus_byte_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .bus           (bus),
    .o_mem_address (mem_address),
    .o_mem_re      (mem_re),
    .o_mem_we      (mem_we),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Physical byte memory with a LAT-deep read pipeline.
  logic [7:0] phys [0:65535];
  logic [7:0] pipe [0:LAT-1];
  initial for (int i = 0; i < 65536; i++) phys[i] = init_byte(16'(i));
  always @(posedge clk) begin
    if (mem_we) phys[mem_address] <= mem_wdata;
    pipe[0] <= mem_re ? phys[mem_address] : 8'hEE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Word-level reference memory keyed by aliased word address.
  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_read(input logic [15:0] a);
    logic [31:0] w;
    if (ref_mem.exists(int'(a[15:2]))) return ref_mem[int'(a[15:2])];
    for (int k = 0; k < 4; k++) w[8*k +: 8] = init_byte({a[15:2], 2'(k)});
    return w;
  endfunction

  strobe_t sq[$];
  resp_t   rq[$];
  int      vectors = 0;
  int      errors  = 0;
  bit      ignore_strobes = 1'b0;
  logic [31:0] last_rdata = '0;

  initial begin
    strobe_t act, exp;
    resp_t   ract, rexp;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if ((mem_re || mem_we) && !ignore_strobes) begin
          act = '{we: mem_we, addr: 16'(mem_address), data: (mem_we ? mem_wdata : 8'h00), cyc: cyc};
          vectors++;
          if (mem_re && mem_we) begin
            errors++;
            $display("FAIL strobe_both: re=%b we=%b at cycle %0d, required one strobe", mem_re, mem_we, cyc);
          end else if (sq.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got we=%b addr=%h data=%h cyc=%0d, required no strobe", act.we, act.addr, act.data, act.cyc);
          end else begin
            exp = sq.pop_front();
            if (act !== exp) begin
              errors++;
              $display("FAIL strobe: got we=%b addr=%h data=%h cyc=%0d, required we=%b addr=%h data=%h cyc=%0d",
                       act.we, act.addr, act.data, act.cyc, exp.we, exp.addr, exp.data, exp.cyc);
            end
          end
        end
        if (bus.o_ready) begin
          ract = '{rdata: bus.o_rdata, cyc: cyc};
          vectors++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL ready_unexpected: got ready at cycle %0d rdata=%h, required no ready", cyc, bus.o_rdata);
          end else begin
            rexp = rq.pop_front();
            if (ract !== rexp) begin
              errors++;
              $display("FAIL response: got rdata=%h cyc=%0d, required rdata=%h cyc=%0d",
                       ract.rdata, ract.cyc, rexp.rdata, rexp.cyc);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a       = $urandom;
    a[15:2] = 14'h40 + 14'($urandom_range(0, 7));
    return a;
  endfunction

  // Issue a transaction accepted in the current cycle, wait for ready,
  // hold the request `hold` extra cycles, then idle `gap` cycles.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                         input int unsigned hold, input int unsigned gap);
    logic [31:0] acc, r, idle_c, word;
    bit got;
    acc = cyc;
    bus.i_request = 1'b1;
    bus.i_rw      = rw;
    bus.i_address = addr;
    bus.i_wdata   = wd;
    if (rw) begin
      for (int k = 0; k < 4; k++)
        sq.push_back('{we: 1'b1, addr: {addr[15:2], 2'(k)}, data: wd[8*k +: 8], cyc: acc + 32'(1 + k)});
      ref_mem[int'(addr[15:2])] = wd;
      rq.push_back('{rdata: last_rdata, cyc: acc + 32'd5});
    end else begin
      word = ref_read(addr[15:0]);
      for (int k = 0; k < 4; k++)
        sq.push_back('{we: 1'b0, addr: {addr[15:2], 2'(k)}, data: 8'h00, cyc: acc + 32'(1 + k * (1 + LAT))});
      rq.push_back('{rdata: word, cyc: acc + 32'(1 + 4 * (1 + LAT))});
      last_rdata = word;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (bus.o_ready) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      errors++;
      $display("FAIL ready_timeout: got no ready within 200 cycles of accept at %0d, required ready", acc);
      finish_run();
      return;
    end
    r = cyc;
    repeat (hold) step();
    bus.i_request = 1'b0;
    bus.i_rw      = 1'($urandom);
    bus.i_address = $urandom;
    bus.i_wdata   = $urandom;
    idle_c = r + ((hold == 0) ? 32'd1 : 32'(hold)) + 32'd1;
    while (cyc < idle_c + 32'(gap)) step();
  endtask

  initial begin
    #2_000_000;
    vectors++;
    errors++;
    $display("FAIL watchdog: got simulation still running, required completion");
    finish_run();
  end

  initial begin
    rst           = 1'b1;
    bus.i_request = 1'b1;
    bus.i_rw      = 1'b0;
    bus.i_address = 32'h0000_0100;
    bus.i_wdata   = '0;
    repeat (2) @(posedge clk);
    step();
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_rdata", bus.o_rdata, 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;

    run_txn(1'b0, 32'h0000_0100, 32'h0, 0, 0);
    run_txn(1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 1, 0);
    run_txn(1'b0, 32'h0000_0206, 32'h0, 6, 2);
    run_txn(1'b0, 32'h0001_0100, 32'h0, 0, 1);

    for (int n = 0; n < 40; n++)
      run_txn(1'($urandom_range(0, 1)), rand_addr(), $urandom,
              $urandom_range(0, 6), $urandom_range(0, 3));

    // Reset in cycle 4 of a read, after a completed read left o_rdata non-zero.
    run_txn(1'b0, 32'h0000_0204, 32'h0, 0, 0);
    ignore_strobes = 1'b1;
    bus.i_request  = 1'b1;
    bus.i_rw       = 1'b0;
    bus.i_address  = 32'h0000_0108;
    repeat (4) step();
    rst           = 1'b1;
    bus.i_request = 1'b0;
    step();
    check("abort_ready", 32'(bus.o_ready), 32'd0);
    check("abort_rdata", bus.o_rdata, 32'd0);
    rst            = 1'b0;
    ignore_strobes = 1'b0;
    last_rdata     = '0;
    run_txn(1'b1, 32'h0000_0000, 32'h0, 0, 0);
    run_txn(1'b0, 32'h0000_0108, 32'h0, 0, 0);

    repeat (5) step();
    check("strobe_queue_drained", 32'(sq.size()), 32'd0);
    check("resp_queue_drained", 32'(rq.size()), 32'd0);
    finish_run();
  end

endmodule

// File: doc/cpu_bus_byte_responder.md
# cpu_bus_byte_responder

Bus target for the CPU request/ready memory bus: it serves 32-bit word reads and writes from an initiator such as the instruction cache or data cache. Each word is carried out as four sequential byte accesses on an 8-bit synchronous memory port. The block sits between the CPU bus and narrow external or on-chip memory. It asserts `o_ready` exactly once per transaction, then waits for the initiator to release the request.

## Interface
- `ADDR_WIDTH`, 16: byte-address width of the memory port; bus address bits above it are ignored (aliasing).
- `LATENCY`, 1: memory read latency in cycles; legal range 1..15.

- `i_clock`  in  1  single clock, all logic on rising edge
- `i_reset`  in  1  reset, synchronous, active-high
- `i_request`  in  1  initiator holds high with stable address/rw/wdata until `o_ready`
- `i_rw`  in  1  1 = write, 0 = read; sampled at accept
- `i_address`  in  32  byte address; bits [1:0] ignored (word aligned)
- `i_wdata`  in  32  write word; sampled at accept
- `o_rdata`  out  32  read word, registered; valid in the `o_ready` cycle, held until the next read completes
- `o_ready`  out  1  one-cycle completion pulse
- `o_mem_address`  out  ADDR_WIDTH  byte address {addr[ADDR_WIDTH-1:2], k}, k = byte index 0..3
- `o_mem_re`  out  1  one-cycle read strobe
- `o_mem_we`  out  1  one-cycle write strobe
- `o_mem_wdata`  out  8  byte to write, valid with `o_mem_we`
- `i_mem_rdata`  in  8  read byte, valid LATENCY cycles after its `o_mem_re` cycle

## Operation
- Byte order is little-endian: byte k maps to word bits [8k+7:8k].
- States are IDLE, ISSUE, WAIT, DONE and HOLD.
- IDLE: when `i_request`=1, latch address, rw and wdata, set k=0 and go to ISSUE. Nothing is latched while `i_request`=0.
- ISSUE (one cycle per byte): drive `o_mem_address` for byte k.
  - Write: assert `o_mem_we`, with `o_mem_wdata` = wdata[8k+7:8k]. If k=3, go to DONE; otherwise k++ and stay in ISSUE.
  - Read: assert `o_mem_re`, load the wait counter with LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle. On the last WAIT cycle (counter=1), capture `i_mem_rdata` into rdata byte k. Then, if k=3, go to DONE; otherwise k++ and go to ISSUE.
- DONE: `o_ready`=1 for this cycle only. For a read, `o_rdata` holds the assembled word in this cycle. Go to HOLD.
- HOLD: stay until `i_request`=0, then go to IDLE. A request still high after `o_ready` is never re-served.
- Memory strobes are 0 in every state except ISSUE. `o_mem_address` and `o_mem_wdata` derive from latched registers and are don't-care outside ISSUE.
- If `i_request` drops mid-transaction (a protocol violation), the transaction still completes and pulses `o_ready`; HOLD then exits immediately.
- Writes do not modify `o_rdata`.

## Timing
- Reset values: state=IDLE, `o_ready`=0, `o_rdata`=0, `o_mem_re`=0, `o_mem_we`=0, `o_mem_address`=0, `o_mem_wdata`=0, k=0, counter=0.
- Reset mid-transaction aborts on the next edge with no `o_ready`. Bytes already written stay written (a partial write is allowed).
- Cycle numbering: cycle 0 is the IDLE cycle in which `i_request` is sampled high.
- Read timing:
  - Byte k is issued in cycle 1+k(1+LATENCY) and captured at the end of cycle (1+k)(1+LATENCY).
  - `o_ready` occurs in cycle 1+4(1+LATENCY); for LATENCY=1, that is cycle 9.
- Write timing: `o_mem_we` is high in cycles 1..4 for k=0..3, and `o_ready` occurs in cycle 5.
- Back-to-back timing:
  - With the request dropped in the cycle after `o_ready`, HOLD exits in that cycle.
  - A new request is accepted two cycles after the `o_ready` cycle.
  - Minimum gap from `o_ready` to the next accept is 2 cycles.
- The block has no combinational path from bus inputs to `o_ready` or `o_rdata`.

## Test plan
- **Reset:** assert `i_reset` for 2 cycles with `i_request`=1 -> all outputs at reset values; first accept occurs in the cycle after reset deasserts.
- **Read, LATENCY=1:** memory model holds bytes 0x11,0x22,0x33,0x44 at 0x100..0x103; read 0x100 -> `o_mem_re` in cycles 1,3,5,7 with addresses 0x100..0x103; `o_ready` in cycle 9 only; `o_rdata`=0x44332211.
- **Write then read back:** write 0xDEADBEEF to 0x0204 -> `o_mem_we` in cycles 1..4, `o_mem_wdata` 0xEF,0xBE,0xAD,0xDE, `o_ready` in cycle 5. Then read 0x0206 -> `o_rdata`=0xDEADBEEF (bits [1:0] ignored).
- **Held request:** keep `i_request` high for 6 cycles after `o_ready` -> no second `o_ready` and no memory strobes; accept resumes 1 cycle after the drop.
- **LATENCY=3 with aliasing:** ADDR_WIDTH=16, read 0x0001_0100 -> `o_mem_address`=0x0100..0x0103; `o_ready` in cycle 17; `o_ready` low in cycles 0..16.
- **Reset mid-read:** assert `i_reset` in cycle 4 of a read -> no `o_ready`, `o_rdata`=0, state IDLE; the next read completes normally.
